axil_addr_decoder: RTL and testbench
====================================

Name: axil_addr_decoder

Overview:
- AXI4-Lite 1-to-N address decoder/demultiplexer between the core DATA interface's AXI master path and the AXI4-Lite peripherals.
- Matches each AW/AR address against a parameterised rule table and forwards the transaction to the selected peripheral port.
- Unmapped accesses are answered internally with DECERR.
- Read and write paths are independent; each path allows one outstanding transaction.

Parameters:
- NUM_SLAVES, 2, number of downstream AXI4-Lite ports (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; STRB width is DATA_W/8.
- RULES, {'{32'h0001_0000,32'h0001_0030}, '{32'h1000_0000,32'h1FFF_0000}}, addr_rule_t array [NUM_SLAVES]; index i maps to port i.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- s_aw*  mixed  ADDR_W+2  upstream AW: s_awaddr, s_awvalid (in); s_awready (out).
- s_w*  mixed  DATA_W+DATA_W/8+2  upstream W: s_wdata, s_wstrb, s_wvalid (in); s_wready (out).
- s_b*  mixed  2+2  upstream B: s_bresp, s_bvalid (out); s_bready (in).
- s_ar*  mixed  ADDR_W+2  upstream AR: s_araddr, s_arvalid (in); s_arready (out).
- s_r*  mixed  DATA_W+2+2  upstream R: s_rdata, s_rresp, s_rvalid (out); s_rready (in).
- m_aw*  mixed  [NUM_SLAVES] x (ADDR_W+2)  downstream AW: m_awaddr, m_awvalid (out); m_awready (in).
- m_w*  mixed  [NUM_SLAVES] x (DATA_W+DATA_W/8+2)  downstream W: m_wdata, m_wstrb, m_wvalid (out); m_wready (in).
- m_b*  mixed  [NUM_SLAVES] x 4  downstream B: m_bresp, m_bvalid (in); m_bready (out).
- m_ar*  mixed  [NUM_SLAVES] x (ADDR_W+2)  downstream AR: m_araddr, m_arvalid (out); m_arready (in).
- m_r*  mixed  [NUM_SLAVES] x (DATA_W+4)  downstream R: m_rdata, m_rresp, m_rvalid (in); m_rready (out).

Behaviour:
- Reset: all valid/ready outputs are 0; s_bresp, s_rresp, s_rdata, and the registered addr/data/strb are 0; both FSMs are in IDLE.
- Decode:
  - hit_i = (addr >= RULES[i].start_addr) && (addr < RULES[i].end_addr); end_addr is exclusive.
  - Lowest matching index wins.
  - No hit: error route.
  - Decode is performed on the registered address.
- Write FSM: W_IDLE -> W_FWD -> W_BWAIT -> W_RESP -> W_IDLE.
  - W_IDLE:
    - s_awready=1 until AW is captured; s_wready=1 until W is captured.
    - AW and W may arrive in either order or the same cycle; each is held once captured.
    - When both are held, go to W_FWD if hit, else to W_RESP with bresp=2'b11.
  - W_FWD:
    - m_awvalid[sel] and m_wvalid[sel] are asserted from registers; each drops independently after its handshake.
    - When both are done, go to W_BWAIT.
    - Valids of non-selected ports stay 0.
  - W_BWAIT: m_bready[sel]=1; on m_bvalid[sel], capture m_bresp and go to W_RESP.
  - W_RESP: s_bvalid=1 holding the captured bresp; on s_bready, go to W_IDLE.
  - Minimum latency (AW+W same cycle, zero-wait slave): s_bvalid rises 3 cycles after the capture edge.
- Read FSM: R_IDLE -> R_FWD -> R_RWAIT -> R_RESP -> R_IDLE.
  - R_IDLE: s_arready=1; capture AR. On hit go to R_FWD; on miss go to R_RESP with rresp=2'b11, rdata=0.
  - R_FWD: m_arvalid[sel]=1 until m_arready[sel].
  - R_RWAIT: m_rready[sel]=1; capture m_rdata and m_rresp on m_rvalid[sel].
  - R_RESP: s_rvalid=1 until s_rready.
- Read and write run concurrently, including to the same port; no ordering is enforced between them.
- Valid signals never depend combinationally on ready; all upstream and downstream outputs are registered.
- Downstream responses arriving outside the WAIT state, or on a non-selected port, are ignored; their ready is held at 0.
- Asserting rst_i mid-transaction aborts both FSMs to IDLE immediately; in-flight downstream transactions are abandoned.
- Overlapping rules are legal; the lowest index takes priority.

Test Plan:
- Write 0x0001_0004, data 0xA5A5_0001, strb 0xF -> port0 sees AW/W with the same values; port0 bresp OKAY -> s_bresp=2'b00; port1 is never valid.
- Read 0x1000_0010; port1 returns rdata 0x1234_5678 after 4 wait cycles -> s_rdata=0x1234_5678, s_rresp=00; port0 is untouched.
- Write to 0x0001_0030 (end boundary) and read 0x2000_0000 -> no downstream valid; s_bresp=11; s_rresp=11 with s_rdata=0.
- W presented 3 cycles before AW; port0 m_awready delayed 2 cycles after m_wready -> exactly one handshake per channel; s_bvalid is held until s_bready after 5 stall cycles.
- Concurrent write to port0 and read from port1 issued the same cycle -> both complete independently with correct data/resp.
- Assert rst_i while in W_BWAIT -> all outputs are 0 the next cycle; a subsequent read completes normally.

Source files
------------

// File: rtl/axil_addr_decoder.sv
// AXI4-Lite 1-to-N address decoder: routes AW/W/B and AR/R to the port whose
// address rule matches, answering unmapped accesses locally with DECERR.
package axil_addr_decoder_pkg;
  typedef struct packed {
    logic [63:0] start_addr;
    logic [63:0] end_addr;
  } addr_rule_t;
endpackage

module axil_addr_decoder
  import axil_addr_decoder_pkg::*;
#(
  parameter int         NUM_SLAVES        = 2,
  parameter int         ADDR_W            = 32,
  parameter int         DATA_W            = 32,
  parameter addr_rule_t RULES [NUM_SLAVES] = '{'{64'h0001_0000, 64'h0001_0030},
                                               '{64'h1000_0000, 64'h1FFF_0000}}
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [ADDR_W-1:0]                   s_awaddr_i,
  input  logic                                s_awvalid_i,
  output logic                                s_awready_o,
  input  logic [DATA_W-1:0]                   s_wdata_i,
  input  logic [DATA_W/8-1:0]                 s_wstrb_i,
  input  logic                                s_wvalid_i,
  output logic                                s_wready_o,
  output logic [1:0]                          s_bresp_o,
  output logic                                s_bvalid_o,
  input  logic                                s_bready_i,
  input  logic [ADDR_W-1:0]                   s_araddr_i,
  input  logic                                s_arvalid_i,
  output logic                                s_arready_o,
  output logic [DATA_W-1:0]                   s_rdata_o,
  output logic [1:0]                          s_rresp_o,
  output logic                                s_rvalid_o,
  input  logic                                s_rready_i,
  output logic [NUM_SLAVES-1:0][ADDR_W-1:0]   m_awaddr_o,
  output logic [NUM_SLAVES-1:0]               m_awvalid_o,
  input  logic [NUM_SLAVES-1:0]               m_awready_i,
  output logic [NUM_SLAVES-1:0][DATA_W-1:0]   m_wdata_o,
  output logic [NUM_SLAVES-1:0][DATA_W/8-1:0] m_wstrb_o,
  output logic [NUM_SLAVES-1:0]               m_wvalid_o,
  input  logic [NUM_SLAVES-1:0]               m_wready_i,
  input  logic [NUM_SLAVES-1:0][1:0]          m_bresp_i,
  input  logic [NUM_SLAVES-1:0]               m_bvalid_i,
  output logic [NUM_SLAVES-1:0]               m_bready_o,
  output logic [NUM_SLAVES-1:0][ADDR_W-1:0]   m_araddr_o,
  output logic [NUM_SLAVES-1:0]               m_arvalid_o,
  input  logic [NUM_SLAVES-1:0]               m_arready_i,
  input  logic [NUM_SLAVES-1:0][DATA_W-1:0]   m_rdata_i,
  input  logic [NUM_SLAVES-1:0][1:0]          m_rresp_i,
  input  logic [NUM_SLAVES-1:0]               m_rvalid_i,
  output logic [NUM_SLAVES-1:0]               m_rready_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  // Returns {hit, sel}; scanning downward lets the lowest matching index win.
  function automatic logic [SEL_W:0] decode(input logic [ADDR_W-1:0] a);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (a >= RULES[i].start_addr[ADDR_W-1:0] && a < RULES[i].end_addr[ADDR_W-1:0])
        r = {1'b1, SEL_W'(i)};
    return r;
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_BWAIT, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RWAIT, R_RESP} rstate_e;

  // ---------------- write path ----------------
  wstate_e               wst_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_W-1:0]     awaddr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [SEL_W-1:0]      wsel_q;
  logic                  s_awready_q, s_wready_q, s_bvalid_q;
  logic [1:0]            bresp_q;
  logic [NUM_SLAVES-1:0] m_awvalid_q, m_wvalid_q, m_bready_q;
  logic [SEL_W:0]        wdec;
  logic                  aw_hs, w_hs, aw_done, w_done;

  assign wdec    = decode(awaddr_q);
  assign aw_hs   = s_awvalid_i && s_awready_q;
  assign w_hs    = s_wvalid_i && s_wready_q;
  assign aw_done = !m_awvalid_q[wsel_q] || m_awready_i[wsel_q];
  assign w_done  = !m_wvalid_q[wsel_q] || m_wready_i[wsel_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wst_q       <= W_IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wsel_q      <= '0;
      s_awready_q <= 1'b0;
      s_wready_q  <= 1'b0;
      s_bvalid_q  <= 1'b0;
      bresp_q     <= 2'b00;
      m_awvalid_q <= '0;
      m_wvalid_q  <= '0;
      m_bready_q  <= '0;
    end else begin
      case (wst_q)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_q  <= s_awaddr_i;
            aw_held_q <= 1'b1;
          end
          if (w_hs) begin
            wdata_q  <= s_wdata_i;
            wstrb_q  <= s_wstrb_i;
            w_held_q <= 1'b1;
          end
          s_awready_q <= !(aw_held_q || aw_hs);
          s_wready_q  <= !(w_held_q || w_hs);
          // Both beats held: ready is already low, so no new capture can race this.
          if (aw_held_q && w_held_q) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            if (wdec[SEL_W]) begin
              wsel_q                     <= wdec[SEL_W-1:0];
              m_awvalid_q[wdec[SEL_W-1:0]] <= 1'b1;
              m_wvalid_q[wdec[SEL_W-1:0]]  <= 1'b1;
              wst_q                      <= W_FWD;
            end else begin
              bresp_q    <= 2'b11;
              s_bvalid_q <= 1'b1;
              wst_q      <= W_RESP;
            end
          end
        end
        W_FWD: begin
          if (m_awready_i[wsel_q]) m_awvalid_q[wsel_q] <= 1'b0;
          if (m_wready_i[wsel_q])  m_wvalid_q[wsel_q]  <= 1'b0;
          if (aw_done && w_done) begin
            m_bready_q[wsel_q] <= 1'b1;
            wst_q              <= W_BWAIT;
          end
        end
        W_BWAIT: begin
          if (m_bvalid_i[wsel_q]) begin
            bresp_q    <= m_bresp_i[wsel_q];
            m_bready_q <= '0;
            s_bvalid_q <= 1'b1;
            wst_q      <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_bready_i) begin
            s_bvalid_q  <= 1'b0;
            s_awready_q <= 1'b1;
            s_wready_q  <= 1'b1;
            wst_q       <= W_IDLE;
          end
        end
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  rstate_e               rst_q;
  logic                  ar_held_q;
  logic [ADDR_W-1:0]     araddr_q;
  logic [SEL_W-1:0]      rsel_q;
  logic                  s_arready_q, s_rvalid_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [1:0]            rresp_q;
  logic [NUM_SLAVES-1:0] m_arvalid_q, m_rready_q;
  logic [SEL_W:0]        rdec;
  logic                  ar_hs;

  assign rdec  = decode(araddr_q);
  assign ar_hs = s_arvalid_i && s_arready_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst_q       <= R_IDLE;
      ar_held_q   <= 1'b0;
      araddr_q    <= '0;
      rsel_q      <= '0;
      s_arready_q <= 1'b0;
      s_rvalid_q  <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
      m_arvalid_q <= '0;
      m_rready_q  <= '0;
    end else begin
      case (rst_q)
        R_IDLE: begin
          if (ar_hs) begin
            araddr_q  <= s_araddr_i;
            ar_held_q <= 1'b1;
          end
          s_arready_q <= !(ar_held_q || ar_hs);
          if (ar_held_q) begin
            ar_held_q <= 1'b0;
            if (rdec[SEL_W]) begin
              rsel_q                       <= rdec[SEL_W-1:0];
              m_arvalid_q[rdec[SEL_W-1:0]] <= 1'b1;
              rst_q                        <= R_FWD;
            end else begin
              rdata_q    <= '0;
              rresp_q    <= 2'b11;
              s_rvalid_q <= 1'b1;
              rst_q      <= R_RESP;
            end
          end
        end
        R_FWD: begin
          if (m_arready_i[rsel_q]) begin
            m_arvalid_q[rsel_q] <= 1'b0;
            m_rready_q[rsel_q]  <= 1'b1;
            rst_q               <= R_RWAIT;
          end
        end
        R_RWAIT: begin
          if (m_rvalid_i[rsel_q]) begin
            rdata_q    <= m_rdata_i[rsel_q];
            rresp_q    <= m_rresp_i[rsel_q];
            m_rready_q <= '0;
            s_rvalid_q <= 1'b1;
            rst_q      <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_rready_i) begin
            s_rvalid_q  <= 1'b0;
            s_arready_q <= 1'b1;
            rst_q       <= R_IDLE;
          end
        end
        default: rst_q <= R_IDLE;
      endcase
    end
  end

  // Payload is broadcast to every port; only the selected valid qualifies it.
  assign s_awready_o = s_awready_q;
  assign s_wready_o  = s_wready_q;
  assign s_bvalid_o  = s_bvalid_q;
  assign s_bresp_o   = bresp_q;
  assign s_arready_o = s_arready_q;
  assign s_rvalid_o  = s_rvalid_q;
  assign s_rdata_o   = rdata_q;
  assign s_rresp_o   = rresp_q;
  assign m_awaddr_o  = {NUM_SLAVES{awaddr_q}};
  assign m_wdata_o   = {NUM_SLAVES{wdata_q}};
  assign m_wstrb_o   = {NUM_SLAVES{wstrb_q}};
  assign m_araddr_o  = {NUM_SLAVES{araddr_q}};
  assign m_awvalid_o = m_awvalid_q;
  assign m_wvalid_o  = m_wvalid_q;
  assign m_bready_o  = m_bready_q;
  assign m_arvalid_o = m_arvalid_q;
  assign m_rready_o  = m_rready_q;
endmodule

// File: tb/tb_axil_addr_decoder.sv
// Scoreboard bench for axil_addr_decoder: expected downstream beats and
// upstream responses are queued at stimulus time and popped on handshakes.
module tb_axil_addr_decoder;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s_awaddr = '0;  logic s_awvalid = 1'b0; logic s_awready;
  logic [31:0] s_wdata = '0;   logic [3:0] s_wstrb = '0; logic s_wvalid = 1'b0; logic s_wready;
  logic [1:0]  s_bresp;        logic s_bvalid; logic s_bready = 1'b1;
  logic [31:0] s_araddr = '0;  logic s_arvalid = 1'b0; logic s_arready;
  logic [31:0] s_rdata;        logic [1:0] s_rresp; logic s_rvalid; logic s_rready = 1'b1;
  logic [NS-1:0][31:0] m_awaddr, m_wdata, m_araddr;
  logic [NS-1:0][3:0]  m_wstrb;
  logic [NS-1:0]       m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [NS-1:0]       m_awready = '1, m_wready = '1, m_arready = '1;
  logic [NS-1:0]       m_bvalid = '0, m_rvalid = '0;
  logic [NS-1:0][1:0]  m_bresp = '0, m_rresp = '0;
  logic [NS-1:0][31:0] m_rdata = '0;

  axil_addr_decoder dut (
    .clk_i(clk), .rst_i(rst),
    .s_awaddr_i(s_awaddr), .s_awvalid_i(s_awvalid), .s_awready_o(s_awready),
    .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wvalid_i(s_wvalid), .s_wready_o(s_wready),
    .s_bresp_o(s_bresp), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready),
    .s_araddr_i(s_araddr), .s_arvalid_i(s_arvalid), .s_arready_o(s_arready),
    .s_rdata_o(s_rdata), .s_rresp_o(s_rresp), .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
    .m_awaddr_o(m_awaddr), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
    .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
    .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
    .m_araddr_o(m_araddr), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready)
  );

  typedef struct { int port; logic [31:0] addr; } addr_t;
  typedef struct { int port; logic [31:0] data; logic [3:0] strb; } wbeat_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;

  addr_t  exp_aw[$], exp_ar[$];
  wbeat_t exp_w[$];
  rsp_t   exp_b[$], exp_r[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int aw_cap = 0;
  int aw_hs[NS];
  int w_hs[NS];

  initial for (int i = 0; i < NS; i++) begin aw_hs[i] = 0; w_hs[i] = 0; end

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes sampled at negedge happen at the following posedge.
  always @(negedge clk) if (!rst) begin
    for (int p = 0; p < NS; p++) begin
      if (m_awvalid[p]) begin
        tests++;
        if (exp_aw.size() == 0 || exp_aw[0].port != p) begin
          fails++; $display("FAIL aw_route: m_awvalid on port %0d, none expected there", p);
        end else if (m_awready[p]) begin
          aw_hs[p]++;
          tests++;
          if (m_awaddr[p] !== exp_aw[0].addr) begin
            fails++; $display("FAIL aw_addr: port %0d got %h want %h", p, m_awaddr[p], exp_aw[0].addr);
          end
          void'(exp_aw.pop_front());
        end
      end
      if (m_wvalid[p]) begin
        tests++;
        if (exp_w.size() == 0 || exp_w[0].port != p) begin
          fails++; $display("FAIL w_route: m_wvalid on port %0d, none expected there", p);
        end else if (m_wready[p]) begin
          w_hs[p]++;
          tests++;
          if (m_wdata[p] !== exp_w[0].data || m_wstrb[p] !== exp_w[0].strb) begin
            fails++; $display("FAIL w_beat: port %0d got %h/%h want %h/%h", p, m_wdata[p], m_wstrb[p],
                              exp_w[0].data, exp_w[0].strb);
          end
          void'(exp_w.pop_front());
        end
      end
      if (m_arvalid[p]) begin
        tests++;
        if (exp_ar.size() == 0 || exp_ar[0].port != p) begin
          fails++; $display("FAIL ar_route: m_arvalid on port %0d, none expected there", p);
        end else if (m_arready[p]) begin
          tests++;
          if (m_araddr[p] !== exp_ar[0].addr) begin
            fails++; $display("FAIL ar_addr: port %0d got %h want %h", p, m_araddr[p], exp_ar[0].addr);
          end
          void'(exp_ar.pop_front());
        end
      end
    end
    if (s_bvalid && s_bready) begin
      tests++;
      if (exp_b.size() == 0) begin
        fails++; $display("FAIL b_extra: unexpected B resp %b", s_bresp);
      end else begin
        if (s_bresp !== exp_b[0].resp) begin
          fails++; $display("FAIL b_resp: got %b want %b", s_bresp, exp_b[0].resp);
        end
        void'(exp_b.pop_front());
      end
    end
    if (s_rvalid && s_rready) begin
      tests++;
      if (exp_r.size() == 0) begin
        fails++; $display("FAIL r_extra: unexpected R %h/%b", s_rdata, s_rresp);
      end else begin
        if (s_rdata !== exp_r[0].data || s_rresp !== exp_r[0].resp) begin
          fails++; $display("FAIL r_beat: got %h/%b want %h/%b", s_rdata, s_rresp, exp_r[0].data, exp_r[0].resp);
        end
        void'(exp_r.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_aw(input logic [31:0] a);
    bit ok = 0;
    @(posedge clk); #1; s_awaddr = a; s_awvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (s_awready) begin aw_cap = cyc + 1; ok = 1; end
    end
    if (ok) begin @(posedge clk); #1; end
    else begin tests++; fails++; $display("FAIL aw_timeout: s_awready got 0 want 1"); end
    s_awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    @(posedge clk); #1; s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (s_wready) ok = 1;
    end
    if (ok) begin @(posedge clk); #1; end
    else begin tests++; fails++; $display("FAIL w_timeout: s_wready got 0 want 1"); end
    s_wvalid = 1'b0;
  endtask

  task automatic drive_ar(input logic [31:0] a);
    bit ok = 0;
    @(posedge clk); #1; s_araddr = a; s_arvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (s_arready) ok = 1;
    end
    if (ok) begin @(posedge clk); #1; end
    else begin tests++; fails++; $display("FAIL ar_timeout: s_arready got 0 want 1"); end
    s_arvalid = 1'b0;
  endtask

  task automatic b_respond(input int p, input logic [1:0] r);
    bit ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (m_bready[p]) ok = 1;
    end
    if (ok) begin
      m_bresp[p] = r; m_bvalid[p] = 1'b1;
      @(posedge clk); #1; m_bvalid[p] = 1'b0;
    end else begin tests++; fails++; $display("FAIL b_timeout: m_bready[%0d] got 0 want 1", p); end
  endtask

  task automatic r_respond(input int p, input int waits, input logic [31:0] d, input logic [1:0] r);
    bit ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (m_rready[p]) ok = 1;
    end
    if (ok) begin
      repeat (waits) @(negedge clk);
      m_rdata[p] = d; m_rresp[p] = r; m_rvalid[p] = 1'b1;
      @(posedge clk); #1; m_rvalid[p] = 1'b0;
    end else begin tests++; fails++; $display("FAIL r_timeout: m_rready[%0d] got 0 want 1", p); end
  endtask

  task automatic wait_drain(output int left);
    left = exp_aw.size() + exp_w.size() + exp_ar.size() + exp_b.size() + exp_r.size();
    for (int n = 0; n < 200 && left != 0; n++) begin
      @(negedge clk);
      left = exp_aw.size() + exp_w.size() + exp_ar.size() + exp_b.size() + exp_r.size();
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid} !== 5'b0) begin
      fails++; $display("FAIL reset_s_ctrl: got %b want 00000", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid});
    end
    tests++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== '0) begin
      fails++; $display("FAIL reset_m_ctrl: got %b want 0", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    tests++;
    if ({s_bresp, s_rresp, s_rdata, m_awaddr, m_wdata, m_wstrb, m_araddr} !== '0) begin
      fails++; $display("FAIL reset_data: got %h/%h/%h want 0", s_rdata, m_awaddr, m_wdata);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      fails++; $display("FAIL idle_ready: got %b want 111", {s_awready, s_wready, s_arready});
    end
  endtask

  task automatic test_write_port0();
    int left;
    int bv_cyc = -1;
    exp_aw.push_back('{0, 32'h0001_0004});
    exp_w.push_back('{0, 32'hA5A5_0001, 4'hF});
    exp_b.push_back('{32'h0, 2'b00});
    fork
      drive_aw(32'h0001_0004);
      drive_w(32'hA5A5_0001, 4'hF);
      b_respond(0, 2'b00);
      for (int n = 0; n < 100 && bv_cyc < 0; n++) begin
        @(negedge clk);
        if (s_bvalid) bv_cyc = cyc;
      end
    join
    tests++;
    if (bv_cyc - aw_cap !== 3) begin
      fails++; $display("FAIL write_latency: got %0d want 3", bv_cyc - aw_cap);
    end
    wait_drain(left);
    tests++;
    if (left !== 0) begin fails++; $display("FAIL write_drain: %0d pending want 0", left); end
  endtask

  task automatic test_read_port1();
    int left;
    exp_ar.push_back('{1, 32'h1000_0010});
    exp_r.push_back('{32'h1234_5678, 2'b00});
    fork
      drive_ar(32'h1000_0010);
      r_respond(1, 4, 32'h1234_5678, 2'b00);
    join
    wait_drain(left);
    tests++;
    if (left !== 0) begin fails++; $display("FAIL read_drain: %0d pending want 0", left); end
  endtask

  task automatic test_decerr();
    int left;
    exp_b.push_back('{32'h0, 2'b11});
    exp_r.push_back('{32'h0, 2'b11});
    fork
      drive_aw(32'h0001_0030);
      drive_w(32'h1111_2222, 4'hF);
      drive_ar(32'h2000_0000);
    join
    wait_drain(left);
    tests++;
    if (left !== 0) begin fails++; $display("FAIL decerr_drain: %0d pending want 0", left); end
  endtask

  task automatic test_w_before_aw();
    int left;
    int aw0 = aw_hs[0];
    int w0  = w_hs[0];
    exp_aw.push_back('{0, 32'h0001_0020});
    exp_w.push_back('{0, 32'h5A5A_7777, 4'h6});
    exp_b.push_back('{32'h0, 2'b00});
    m_awready[0] = 1'b0;
    s_bready = 1'b0;
    fork
      drive_w(32'h5A5A_7777, 4'h6);
      begin repeat (3) @(posedge clk); drive_aw(32'h0001_0020); end
      begin
        bit seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
          @(negedge clk);
          if (m_wvalid[0] && m_wready[0]) seen = 1;
        end
        repeat (3) @(posedge clk);
        #1; m_awready[0] = 1'b1;
      end
      b_respond(0, 2'b00);
    join
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      tests++;
      if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
        fails++; $display("FAIL b_hold: cycle %0d got %b/%b want 1/00", n, s_bvalid, s_bresp);
      end
    end
    @(posedge clk); #1; s_bready = 1'b1;
    wait_drain(left);
    tests++;
    if (left !== 0) begin fails++; $display("FAIL stall_drain: %0d pending want 0", left); end
    tests++;
    if (aw_hs[0] - aw0 !== 1 || w_hs[0] - w0 !== 1) begin
      fails++; $display("FAIL hs_count: aw %0d w %0d want 1 1", aw_hs[0] - aw0, w_hs[0] - w0);
    end
  endtask

  task automatic test_concurrent();
    int left;
    exp_aw.push_back('{0, 32'h0001_0010});
    exp_w.push_back('{0, 32'hDEAD_BEEF, 4'h3});
    exp_b.push_back('{32'h0, 2'b10});
    exp_ar.push_back('{1, 32'h1FFE_FFFC});
    exp_r.push_back('{32'hCAFE_F00D, 2'b01});
    fork
      drive_aw(32'h0001_0010);
      drive_w(32'hDEAD_BEEF, 4'h3);
      drive_ar(32'h1FFE_FFFC);
      b_respond(0, 2'b10);
      r_respond(1, 1, 32'hCAFE_F00D, 2'b01);
    join
    wait_drain(left);
    tests++;
    if (left !== 0) begin fails++; $display("FAIL concurrent_drain: %0d pending want 0", left); end
  endtask

  task automatic test_reset_mid();
    int left;
    bit seen = 0;
    exp_aw.push_back('{1, 32'h1000_0100});
    exp_w.push_back('{1, 32'h0F0F_0F0F, 4'hF});
    fork
      drive_aw(32'h1000_0100);
      drive_w(32'h0F0F_0F0F, 4'hF);
    join
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (m_bready[1]) seen = 1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL bwait_reach: m_bready[1] got 0 want 1"); end
    rst = 1'b1;
    #1;
    tests++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== '0) begin
      fails++; $display("FAIL abort_ctrl: got %b want 0",
                        {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    @(negedge clk);
    tests++;
    if ({s_bresp, s_rresp, s_rdata, m_awaddr, m_wdata, m_wstrb, m_bready} !== '0) begin
      fails++; $display("FAIL abort_data: got %h/%h/%b want 0", m_awaddr, m_wdata, m_bready);
    end
    exp_aw.delete(); exp_w.delete(); exp_b.delete();
    @(posedge clk); #1; rst = 1'b0;
    exp_ar.push_back('{0, 32'h0001_0000});
    exp_r.push_back('{32'h0BAD_CAFE, 2'b00});
    fork
      drive_ar(32'h0001_0000);
      r_respond(0, 2, 32'h0BAD_CAFE, 2'b00);
    join
    wait_drain(left);
    tests++;
    if (left !== 0) begin fails++; $display("FAIL post_reset_read: %0d pending want 0", left); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_port0();
    test_read_port1();
    test_decerr();
    test_w_before_aw();
    test_concurrent();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
